stream_select_arbiter: RTL and testbench

- Packet-aware N:1 stream arbiter that shares one downstream stream between PORTS requesters.
- Selection policy is set by a stream_select_mode_t parameter:
  - ROUND_ROBIN: fair rotation among requesters.
  - ORDERED: an external order stream names the next port to serve.
- A grant is held for a whole packet, from the first beat through the beat with last=1.
- Output goes through one registered stage. Throughput is full: one beat per cycle, including back-to-back packets.

---
 rtl/stream_select_arbiter.sv | 150 +++++++++++++++
 tb/tb_stream_select_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_select_arbiter.sv
// Packet-aware N:1 stream arbiter with round-robin or externally ordered port
// selection; a grant is held from first beat to last beat, output is registered.
package stream_pkg;
  typedef enum logic [0:0] {
    STREAM_SELECT_MODE_ROUND_ROBIN,
    STREAM_SELECT_MODE_ORDERED
  } stream_select_mode_t;
endpackage

module stream_select_arbiter
  import stream_pkg::*;
#(
  parameter int                  PORTS       = 4,
  parameter int                  DATA_WIDTH  = 32,
  parameter stream_select_mode_t SELECT_MODE = STREAM_SELECT_MODE_ROUND_ROBIN,
  parameter int                  ID_WIDTH    = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            in_valid,
  output logic [PORTS-1:0]            in_ready,
  input  logic [PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]            in_last,
  input  logic                        order_valid,
  output logic                        order_ready,
  input  logic [ID_WIDTH-1:0]         order_id,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic [ID_WIDTH-1:0]         out_id
);

  localparam bit ORDERED = (SELECT_MODE == STREAM_SELECT_MODE_ORDERED);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   lock_q, lock_d;
  logic [ID_WIDTH-1:0]   rr_q, rr_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  logic                  load_en;
  logic                  gnt_vld;
  logic [ID_WIDTH-1:0]   gnt;
  logic                  id_ok;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  drop;
  int                    idx;

  assign load_en = !out_valid_q || out_ready;

  // Grant selection: locked port wins, otherwise the mode's policy in IDLE.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    id_ok   = 1'b0;
    idx     = 0;
    for (int i = 0; i < PORTS; i++)
      if (order_id == ID_WIDTH'(i)) id_ok = 1'b1;
    if (state_q == S_LOCKED) begin
      gnt     = lock_q;
      gnt_vld = 1'b1;
    end else if (ORDERED) begin
      gnt     = order_id;
      gnt_vld = order_valid && id_ok;
    end else begin
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        if (!gnt_vld && in_valid[ID_WIDTH'(idx)]) begin
          gnt     = ID_WIDTH'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  // Decode the grant into per-port ready and the selected beat.
  always_comb begin
    in_ready  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (gnt == ID_WIDTH'(i)) begin
        in_ready[i] = gnt_vld && load_en && !rst;
        sel_valid   = in_valid[i];
        sel_last    = in_last[i];
        sel_data    = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept      = gnt_vld && load_en && sel_valid && !rst;
  // An out-of-range token is swallowed so it cannot block the order stream.
  assign drop        = ORDERED && (state_q == S_IDLE) && order_valid && !id_ok && !rst;
  assign order_ready = ORDERED && ((accept && sel_last) || drop);

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    if (accept) begin
      if (sel_last) begin
        state_d = S_IDLE;
        rr_d    = (gnt == ID_WIDTH'(PORTS-1)) ? '0 : gnt + 1'b1;
      end else begin
        state_d = S_LOCKED;
        lock_d  = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lock_q      <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      if (load_en) begin
        out_valid_q <= accept;
        if (accept) begin
          out_data_q <= sel_data;
          out_last_q <= sel_last;
          out_id_q   <= gnt;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_stream_select_arbiter.sv
// Randomised bench for stream_select_arbiter: queue-based sources and a
// transaction-level reference model, round-robin and ordered instances.
module tb_stream_select_arbiter;
  import stream_pkg::*;

  localparam int P  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [P-1:0]   in_valid = '0;
  logic [P-1:0]   in_last  = '0;
  logic [P*W-1:0] in_data  = '0;
  logic           order_valid = 1'b0;
  logic [IW-1:0]  order_id    = '0;
  logic           out_ready   = 1'b0;

  logic [P-1:0]  rr_in_ready, od_in_ready;
  logic          rr_order_ready, od_order_ready;
  logic          rr_out_valid, od_out_valid;
  logic [W-1:0]  rr_out_data, od_out_data;
  logic          rr_out_last, od_out_last;
  logic [IW-1:0] rr_out_id, od_out_id;

  bit mode = 1'b0;  // 0: round-robin instance under check, 1: ordered instance

  wire [P-1:0]  a_in_ready    = mode ? od_in_ready    : rr_in_ready;
  wire          a_order_ready = mode ? od_order_ready : rr_order_ready;
  wire          a_out_valid   = mode ? od_out_valid   : rr_out_valid;
  wire [W-1:0]  a_out_data    = mode ? od_out_data    : rr_out_data;
  wire          a_out_last    = mode ? od_out_last    : rr_out_last;
  wire [IW-1:0] a_out_id      = mode ? od_out_id      : rr_out_id;

  stream_select_arbiter #(.PORTS(P), .DATA_WIDTH(W),
    .SELECT_MODE(STREAM_SELECT_MODE_ROUND_ROBIN)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
    .in_data(in_data), .in_last(in_last), .order_valid(order_valid),
    .order_ready(rr_order_ready), .order_id(order_id), .out_valid(rr_out_valid),
    .out_ready(out_ready), .out_data(rr_out_data), .out_last(rr_out_last),
    .out_id(rr_out_id));

  stream_select_arbiter #(.PORTS(P), .DATA_WIDTH(W),
    .SELECT_MODE(STREAM_SELECT_MODE_ORDERED)) u_od (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(od_in_ready),
    .in_data(in_data), .in_last(in_last), .order_valid(order_valid),
    .order_ready(od_order_ready), .order_id(order_id), .out_valid(od_out_valid),
    .out_ready(out_ready), .out_data(od_out_data), .out_last(od_out_last),
    .out_id(od_out_id));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Source and order queues plus reference model state.
  beat_t q[P][$];
  int    tok_q[$];
  int    rdy_pat[$];
  int    delay[P];
  bit    held[P];
  int    gap_pct = 0;
  int    rdy_pct = 100;

  int           owner = -1;
  int           rr    = 0;
  bit           m_ov  = 0;
  logic [W-1:0] m_od  = '0;
  bit           m_ol  = 0;
  int           m_oid = 0;

  task automatic push_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = $urandom;
      b.l = (i == len - 1);
      q[p].push_back(b);
    end
  endtask

  task automatic push_beat(input int p, input logic [W-1:0] d, input bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    q[p].push_back(b);
  endtask

  task automatic step();
    logic [P-1:0] exp_rdy;
    bit exp_ord, ld, gv, acc, v;
    int g;
    @(negedge clk);
    for (int p = 0; p < P; p++) begin
      v = 1'b0;
      if (q[p].size() > 0 && delay[p] == 0)
        v = held[p] || ($urandom_range(99) >= gap_pct);
      if (rst) v = 1'b1;
      in_valid[p]       = v;
      in_data[p*W +: W] = (q[p].size() > 0) ? q[p][0].d : '0;
      in_last[p]        = (q[p].size() > 0) ? q[p][0].l : 1'b0;
    end
    if (rdy_pat.size() > 0) out_ready = (rdy_pat.pop_front() != 0);
    else                    out_ready = ($urandom_range(99) < rdy_pct);
    order_valid = (tok_q.size() > 0);
    order_id    = order_valid ? IW'(tok_q[0]) : '0;
    #1;
    exp_rdy = '0; exp_ord = 0; acc = 0; gv = 0; g = 0; ld = 0;
    if (!rst) begin
      ld = !m_ov || out_ready;
      if (owner >= 0) begin
        gv = 1; g = owner;
      end else if (!mode) begin
        for (int k = 0; k < P; k++)
          if (!gv && in_valid[(rr + k) % P]) begin gv = 1; g = (rr + k) % P; end
      end else if (order_valid) begin
        gv = 1; g = tok_q[0];
      end
      if (gv && ld) exp_rdy[g] = 1'b1;
      acc     = gv && ld && in_valid[g];
      exp_ord = mode && acc && in_last[g];
    end
    check("in_ready", a_in_ready, exp_rdy);
    check("order_ready", a_order_ready, exp_ord);
    for (int p = 0; p < P; p++) begin
      if (rst) held[p] = 0;
      else if (in_valid[p]) begin
        if (exp_rdy[p]) begin void'(q[p].pop_front()); held[p] = 0; end
        else held[p] = 1;
      end
      if (delay[p] > 0) delay[p]--;
    end
    if (exp_ord) void'(tok_q.pop_front());
    if (rst) begin
      owner = -1; rr = 0; m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0;
    end else begin
      if (acc) begin
        if (in_last[g]) begin owner = -1; rr = (g + 1) % P; end
        else owner = g;
      end
      if (ld) begin
        m_ov = acc;
        if (acc) begin m_od = in_data[g*W +: W]; m_ol = in_last[g]; m_oid = g; end
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", a_out_valid, m_ov);
    check("out_data", a_out_data, m_od);
    check("out_last", a_out_last, m_ol);
    check("out_id", a_out_id, m_oid);
  endtask

  function automatic bit busy();
    busy = m_ov || (tok_q.size() > 0);
    for (int p = 0; p < P; p++) if (q[p].size() > 0) busy = 1;
  endfunction

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (busy() && n < max) begin step(); n++; end
    check(tag, (n < max), 1);
  endtask

  task automatic flush();
    for (int p = 0; p < P; p++) begin q[p].delete(); held[p] = 0; delay[p] = 0; end
    tok_q.delete();
  endtask

  initial begin
    int n;
    for (int p = 0; p < P; p++) begin delay[p] = 0; held[p] = 0; end

    // Reset with every port valid, then round-robin fairness on single beats.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      for (int p = 0; p < P; p++) push_beat(p, 32'h100 * p + i, 1'b1);
    drain("rr_fair_drain", 100);

    // Packet lock on port 1 while port 0 keeps requesting.
    push_beat(1, 32'hA1, 1'b0); push_beat(1, 32'hA2, 1'b0); push_beat(1, 32'hA3, 1'b1);
    for (int i = 0; i < 4; i++) push_beat(0, 32'hB0 + i, 1'b1);
    drain("lock_drain", 100);

    // Backpressure during a 2-beat packet from port 2.
    rdy_pat = '{1, 0, 0, 1, 1, 1};
    push_beat(2, 32'hC1, 1'b0); push_beat(2, 32'hC2, 1'b1);
    drain("bp_drain", 100);

    // Random round-robin traffic.
    gap_pct = 30; rdy_pct = 70;
    for (int i = 0; i < 60; i++) push_pkt($urandom_range(P-1), $urandom_range(1, 4));
    drain("rr_rand_drain", 3000);

    // Reset in the middle of a 3-beat packet from port 3.
    gap_pct = 0; rdy_pct = 100;
    push_pkt(3, 3);
    n = 0;
    while (q[3].size() > 2 && n < 20) begin step(); n++; end
    check("midrst_bound", (n < 20), 1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    flush();
    push_beat(0, 32'hD0, 1'b1);
    push_beat(3, 32'hD3, 1'b1);
    drain("midrst_drain", 50);

    // Ordered instance: tokens 2,0 with port 2 arriving late.
    mode = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    flush();
    tok_q = '{2, 0};
    push_pkt(0, 2);
    push_pkt(2, 1);
    delay[2] = 3;
    drain("ord_dir_drain", 100);

    // Random ordered traffic; each token has a matching packet queued.
    gap_pct = 30; rdy_pct = 70;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(P-1);
      tok_q.push_back(n);
      push_pkt(n, $urandom_range(1, 4));
    end
    drain("ord_rand_drain", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
